// File: rtl/timer_sched.sv
// Shared one-shot down-counter for N requesters with round-robin arbitration.
// Each channel posts a delay; the granted owner receives a one-cycle done pulse on expiry.
module timer_sched #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N-1:0]          req,
    input  logic [N*W-1:0]        delay,
    input  logic [N-1:0]          cancel,
    output logic [N-1:0]          busy,
    output logic [N-1:0]          done,
    output logic                  active,
    output logic [$clog2(N)-1:0]  owner,
    output logic [W-1:0]          count
);
    localparam int OW = $clog2(N);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_q, state_d;
    logic [N-1:0]        pending_q, pending_d;
    logic [N-1:0][W-1:0] dly_q, dly_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic [OW-1:0]       last_q, last_d;
    logic [W-1:0]        count_q, count_d;
    logic [N-1:0]        done_q, done_d;

    logic [N-1:0]        cand;
    logic [OW-1:0]       pick;
    logic                found;

    // A channel cancelled on this edge is not eligible for a grant on the same edge.
    always_comb begin
        cand  = pending_q & ~cancel;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            int unsigned idx;
            idx = (32'(last_q) + k) % N;
            if (!found && cand[idx]) begin
                found = 1'b1;
                pick  = OW'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        dly_d     = dly_q;
        owner_d   = owner_q;
        last_d    = last_q;
        count_d   = count_q;
        done_d    = '0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d = pick;
                    count_d = dly_q[pick];
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cancel[owner_q]) begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end else if (count_q == '0) begin
                    done_d[owner_q]    = 1'b1;
                    pending_d[owner_q] = 1'b0;
                    last_d             = owner_q;
                    state_d            = IDLE;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Capture is gated by the registered pending bit, so a req on the done edge is dropped.
        for (int unsigned i = 0; i < N; i++) begin
            if (cancel[i]) begin
                pending_d[i] = 1'b0;
            end else if (req[i] && !pending_q[i]) begin
                pending_d[i] = 1'b1;
                dly_d[i]     = delay[i*W +: W];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            dly_q     <= '0;
            owner_q   <= '0;
            last_q    <= OW'(N-1);
            count_q   <= '0;
            done_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            dly_q     <= dly_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            count_q   <= count_d;
            done_q    <= done_d;
        end
    end

    assign busy   = pending_q;
    assign done   = done_q;
    assign active = (state_q == RUN);
    assign owner  = owner_q;
    assign count  = count_q;

endmodule

// File: tb/tb_timer_sched.sv
// Self-checking bench for timer_sched: directed scenarios plus a randomized run
// checked cycle by cycle against a behavioural model of the scheduling rules.
module tb_timer_sched;
    localparam int N = 4;
    localparam int W = 8;

    logic           clock;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] delay;
    logic [N-1:0]   cancel;
    logic [N-1:0]   busy;
    logic [N-1:0]   done;
    logic           active;
    logic [1:0]     owner;
    logic [W-1:0]   count;

    int n_checks = 0;
    int n_fail   = 0;

    timer_sched #(.N(N), .W(W)) dut (
        .clock  (clock),
        .reset  (reset),
        .req    (req),
        .delay  (delay),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .active (active),
        .owner  (owner),
        .count  (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state
    bit       m_pend [N];
    int       m_dly  [N];
    bit       m_run;
    int       m_owner, m_cnt, m_last;
    bit [N-1:0] m_done;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_delay(input int ch, input int v);
        delay[ch*W +: W] = W'(v);
    endtask

    task automatic do_reset();
        req    = '0;
        cancel = '0;
        delay  = '0;
        reset  = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic model_init();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0;
            m_dly[i]  = 0;
        end
        m_run = 0; m_owner = 0; m_cnt = 0; m_last = N-1; m_done = '0;
    endtask

    // One clock edge of the scheduling rules, evaluated on pre-edge state.
    task automatic model_step(input bit [N-1:0] r, input bit [N-1:0] c, input bit [N*W-1:0] d);
        bit old_pend [N];
        for (int i = 0; i < N; i++) old_pend[i] = m_pend[i];
        m_done = '0;
        if (m_run) begin
            if (c[m_owner]) begin
                m_run = 0; m_last = m_owner;
            end else if (m_cnt == 0) begin
                m_done[m_owner] = 1'b1;
                m_pend[m_owner] = 0;
                m_last = m_owner;
                m_run = 0;
            end else begin
                m_cnt = m_cnt - 1;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (m_last + k) % N;
                if (!m_run && old_pend[idx] && !c[idx]) begin
                    m_run = 1; m_owner = idx; m_cnt = m_dly[idx];
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (c[i]) m_pend[i] = 0;
            else if (r[i] && !old_pend[i]) begin
                m_pend[i] = 1;
                m_dly[i]  = int'(d[i*W +: W]);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({busy, done, active, owner, count} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b active=%b owner=%0d count=%0d, need all zero",
                     busy, done, active, owner, count);
        end
    endtask

    task automatic test_single();
        do_reset();
        req[0] = 1'b1; set_delay(0, 5);
        tick(); // E0
        req = '0;
        n_checks++;
        if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL single_busy_capture: got %b need 1", busy[0]); end
        for (int k = 1; k <= 9; k++) begin
            tick();
            n_checks++;
            if (done !== ((k == 7) ? 4'b0001 : 4'b0000)) begin
                n_fail++; $display("FAIL single_done E%0d: got %b need %b", k, done, (k == 7) ? 4'b0001 : 4'b0000);
            end
            n_checks++;
            if (busy[0] !== ((k < 7) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL single_busy E%0d: got %b need %b", k, busy[0], k < 7);
            end
            if (k == 1 || k == 2) begin
                n_checks++;
                if (count !== W'(7 - k - 1)) begin
                    n_fail++; $display("FAIL single_count E%0d: got %0d need %0d", k, count, 7 - k - 1);
                end
            end
        end
    endtask

    task automatic test_zero_delay();
        do_reset();
        req[2] = 1'b1; set_delay(2, 0);
        tick(); req = '0;
        tick(); // E1 grant
        n_checks++;
        if ({active, owner, count} !== {1'b1, 2'd2, 8'd0}) begin
            n_fail++; $display("FAIL zero_grant: got active=%b owner=%0d count=%0d need 1/2/0", active, owner, count);
        end
        tick(); // E2 done
        n_checks++;
        if ({done, active, count} !== {4'b0100, 1'b0, 8'd0}) begin
            n_fail++; $display("FAIL zero_done: got done=%b active=%b count=%0d need 0100/0/0", done, active, count);
        end
    endtask

    task automatic test_back_to_back();
        int exp_done [N] = '{5, 8, 12, 14};
        int exp_gnt  [N] = '{1, 6, 9, 13};
        logic [N-1:0] ed;
        do_reset();
        req = '1;
        set_delay(0, 3); set_delay(1, 1); set_delay(2, 2); set_delay(3, 0);
        tick(); req = '0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            ed = '0;
            for (int ch = 0; ch < N; ch++) if (exp_done[ch] == k) ed[ch] = 1'b1;
            n_checks++;
            if (done !== ed) begin n_fail++; $display("FAIL b2b_done E%0d: got %b need %b", k, done, ed); end
            for (int ch = 0; ch < N; ch++) begin
                if (exp_gnt[ch] == k) begin
                    n_checks++;
                    if ({active, owner} !== {1'b1, 2'(ch)}) begin
                        n_fail++; $display("FAIL b2b_grant E%0d: got active=%b owner=%0d need 1/%0d", k, active, owner, ch);
                    end
                end
            end
        end
    endtask

    task automatic test_cancel();
        do_reset();
        req[1] = 1'b1; set_delay(1, 10);
        req[3] = 1'b1; set_delay(3, 2);
        tick(); req = '0;
        tick(); // E1
        n_checks++;
        if ({active, owner} !== {1'b1, 2'd1}) begin
            n_fail++; $display("FAIL cancel_grant: got active=%b owner=%0d need 1/1", active, owner);
        end
        repeat (3) tick();
        cancel[1] = 1'b1;
        tick(); // E5
        cancel = '0;
        n_checks++;
        if ({active, busy, done} !== {1'b0, 4'b1000, 4'b0000}) begin
            n_fail++; $display("FAIL cancel_abort: got active=%b busy=%b done=%b need 0/1000/0000", active, busy, done);
        end
        for (int k = 6; k <= 10; k++) begin
            tick();
            if (k == 6) begin
                n_checks++;
                if ({active, owner, count} !== {1'b1, 2'd3, 8'd2}) begin
                    n_fail++; $display("FAIL cancel_next_grant: got active=%b owner=%0d count=%0d need 1/3/2", active, owner, count);
                end
            end
            n_checks++;
            if (done !== ((k == 9) ? 4'b1000 : 4'b0000)) begin
                n_fail++; $display("FAIL cancel_done E%0d: got %b need %b", k, done, (k == 9) ? 4'b1000 : 4'b0000);
            end
        end
    endtask

    task automatic test_req_ignored();
        do_reset();
        req[1] = 1'b1; set_delay(1, 1);
        tick(); req = '0;
        tick(); tick();
        req[1] = 1'b1; set_delay(1, 4);
        tick(); // done edge
        req = '0;
        n_checks++;
        if ({done[1], busy[1]} !== 2'b10) begin
            n_fail++; $display("FAIL done_edge_req: got done1=%b busy1=%b need 1/0", done[1], busy[1]);
        end
        tick();
        n_checks++;
        if ({busy[1], active} !== 2'b00) begin
            n_fail++; $display("FAIL done_edge_req_after: got busy1=%b active=%b need 0/0", busy[1], active);
        end
        req[1] = 1'b1; cancel[1] = 1'b1;
        tick();
        req = '0; cancel = '0;
        n_checks++;
        if (busy[1] !== 1'b0) begin n_fail++; $display("FAIL req_cancel_capture: got busy1=%b need 0", busy[1]); end
        tick();
        n_checks++;
        if (active !== 1'b0) begin n_fail++; $display("FAIL req_cancel_active: got %b need 0", active); end
    endtask

    task automatic test_max_delay();
        int first_done;
        do_reset();
        req[0] = 1'b1; set_delay(0, 255);
        tick(); req = '0;
        tick();
        n_checks++;
        if (count !== 8'd255) begin n_fail++; $display("FAIL max_count: got %0d need 255", count); end
        first_done = -1;
        for (int k = 2; k <= 260; k++) begin
            tick();
            if (done[0] === 1'b1 && first_done < 0) first_done = k;
        end
        n_checks++;
        if (first_done != 257) begin n_fail++; $display("FAIL max_done_edge: got E%0d need E257", first_done); end
    endtask

    task automatic test_async_reset();
        do_reset();
        req[2] = 1'b1; set_delay(2, 50);
        tick(); req = '0;
        repeat (4) tick();
        n_checks++;
        if (active !== 1'b1) begin n_fail++; $display("FAIL areset_pre_active: got %b need 1", active); end
        #3 reset = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, active, owner, count} !== '0) begin
            n_fail++;
            $display("FAIL areset_immediate: got busy=%b done=%b active=%b owner=%0d count=%0d need all zero",
                     busy, done, active, owner, count);
        end
        #2 reset = 1'b1;
        req = '1;
        for (int ch = 0; ch < N; ch++) set_delay(ch, 1);
        tick(); req = '0;
        tick();
        n_checks++;
        if ({active, owner} !== {1'b1, 2'd0}) begin
            n_fail++; $display("FAIL areset_first_owner: got active=%b owner=%0d need 1/0", active, owner);
        end
    endtask

    task automatic test_random();
        bit [N-1:0]   r, c;
        bit [N*W-1:0] d;
        do_reset();
        model_init();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            r = '0; c = '0; d = '0;
            for (int i = 0; i < N; i++) begin
                r[i] = ($urandom_range(0, 3) == 0);
                c[i] = ($urandom_range(0, 31) == 0);
                d[i*W +: W] = ($urandom_range(0, 15) == 0) ? W'($urandom_range(0, 40)) : W'($urandom_range(0, 6));
            end
            req = r; cancel = c; delay = d;
            model_step(r, c, d);
            tick();
            n_checks++;
            if (done !== m_done) begin n_fail++; $display("FAIL rand_done cyc%0d: got %b need %b", cyc, done, m_done); end
            n_checks++;
            if (active !== m_run) begin n_fail++; $display("FAIL rand_active cyc%0d: got %b need %b", cyc, active, m_run); end
            n_checks++;
            if (owner !== 2'(m_owner)) begin n_fail++; $display("FAIL rand_owner cyc%0d: got %0d need %0d", cyc, owner, m_owner); end
            n_checks++;
            if (count !== W'(m_cnt)) begin n_fail++; $display("FAIL rand_count cyc%0d: got %0d need %0d", cyc, count, m_cnt); end
            for (int i = 0; i < N; i++) begin
                n_checks++;
                if (busy[i] !== m_pend[i]) begin
                    n_fail++; $display("FAIL rand_busy%0d cyc%0d: got %b need %b", i, cyc, busy[i], m_pend[i]);
                end
            end
        end
        req = '0; cancel = '0;
    endtask

    initial begin
        req = '0; cancel = '0; delay = '0; reset = 1'b0;
        test_reset();
        test_single();
        test_zero_delay();
        test_back_to_back();
        test_cancel();
        test_req_ignored();
        test_max_delay();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
